// File: rtl/dmem_sized.sv
// Byte-addressable data memory with byte/half/word loads and stores, a fixed
// number of wait states per access, and error flagging for bad requests.
module dmem_sized #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        err
);

  localparam int AW      = $clog2(DEPTH);
  localparam bit NO_WAIT = (WAIT == 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] a_q, wd_q;
  logic [31:0] rd_q;
  logic        ready_q, err_q;

  logic        cur_we, cur_uns;
  logic [1:0]  cur_size;
  logic [31:0] cur_a, cur_wd;
  logic        go_done, bad, wr_en;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wdata, rword;
  logic [31:0] rd_d;
  logic        err_d;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // With no wait states the access edge is the accept edge, so the live
  // inputs are used; otherwise the request latched at accept is used.
  always_comb begin
    cur_we   = (state_q == IDLE) ? we   : we_q;
    cur_uns  = (state_q == IDLE) ? uns  : uns_q;
    cur_size = (state_q == IDLE) ? size : size_q;
    cur_a    = (state_q == IDLE) ? a    : a_q;
    cur_wd   = (state_q == IDLE) ? wd   : wd_q;
  end

  always_comb begin
    go_done = ((state_q == IDLE) && req && NO_WAIT) ||
              ((state_q == BUSY) && (cnt_q == 3'd0));
    bad = (cur_size == 2'b11) ||
          ((cur_size == 2'b01) && cur_a[0]) ||
          ((cur_size == 2'b10) && (cur_a[1:0] != 2'b00)) ||
          ((cur_a[31:2] >> AW) != 30'd0);
    idx   = cur_a[AW+1:2];
    // rst_n gating stops a zero-wait access from writing while held in reset
    wr_en = go_done && cur_we && !bad && rst_n;
  end

  always_comb begin
    be    = 4'b0000;
    wdata = cur_wd;
    case (cur_size)
      2'b00: begin
        be    = 4'b0001 << cur_a[1:0];
        wdata = {4{cur_wd[7:0]}};
      end
      2'b01: begin
        be    = cur_a[1] ? 4'b1100 : 4'b0011;
        wdata = {2{cur_wd[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en && be[gi]) begin
        mem[idx] <= wdata[gi*8 +: 8];
      end
    end

    assign rword[gi*8 +: 8] = mem[idx];
  end

  always_comb begin
    case (cur_a[1:0])
      2'b00:   rbyte = rword[7:0];
      2'b01:   rbyte = rword[15:8];
      2'b10:   rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = cur_a[1] ? rword[31:16] : rword[15:0];
    err_d = bad;
    if (bad || cur_we) begin
      rd_d = 32'd0;
    end else begin
      case (cur_size)
        2'b00:   rd_d = {{24{rbyte[7] & ~cur_uns}}, rbyte};
        2'b01:   rd_d = {{16{rhalf[15] & ~cur_uns}}, rhalf};
        default: rd_d = rword;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      a_q     <= 32'd0;
      wd_q    <= 32'd0;
      rd_q    <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (req) begin
            we_q   <= we;
            uns_q  <= uns;
            size_q <= size;
            a_q    <= a;
            wd_q   <= wd;
            if (NO_WAIT) begin
              state_q <= DONE;
              ready_q <= 1'b1;
              rd_q    <= rd_d;
              err_q   <= err_d;
            end else begin
              state_q <= BUSY;
              cnt_q   <= 3'(WAIT - 1);
            end
          end
        end
        BUSY: begin
          if (go_done) begin
            state_q <= DONE;
            ready_q <= 1'b1;
            rd_q    <= rd_d;
            err_q   <= err_d;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign rd    = rd_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: doc/dmem_sized.md
DMEM_SIZED -- requirements
Module: dmem_sized

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit words (power of two, 4..4096).
REQ-002 SHALL have parameter WAIT, default 1, meaning wait states added before each access (0..7).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  1  access request, sampled only in IDLE.
REQ-006 SHALL have port we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port uns  input  1  1 = zero-extend loads, 0 = sign-extend loads.
REQ-009 SHALL have port a  input  32  byte address.
REQ-010 SHALL have port wd  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port rd  output  32  load result, extended to 32 bits.
REQ-012 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-013 SHALL have port err  output  1  error flag, valid only while ready=1.

Function
REQ-014 SHALL implement states IDLE, BUSY and DONE.
REQ-015 SHALL accept a request on a rising edge in IDLE with req=1, latching we, size, uns, a and wd at that edge.
REQ-016 SHALL ignore req and all request inputs outside IDLE; no queuing.
REQ-017 SHALL transition IDLE->DONE on accept when WAIT=0, or IDLE->BUSY with wait counter = WAIT-1 when WAIT>0.
REQ-018 SHALL, in BUSY, decrement the counter each edge and go to DONE on the edge where the counter is 0.
REQ-019 SHALL perform the memory access (write commit, read capture into rd) on the edge entering DONE, i.e. accept edge + WAIT edges.
REQ-020 SHALL assert ready for exactly the one cycle spent in DONE, then return to IDLE; next accept is possible on the DONE->IDLE edge only if req=1 in IDLE afterwards (minimum spacing WAIT+2 cycles).
REQ-021 SHALL hold rd and err stable from DONE until the next access edge.
REQ-022 SHALL flag misalignment: half with a[0]=1, word with a[1:0]!=00.
REQ-023 SHALL flag out of range: a[31:2] >= DEPTH.
REQ-024 SHALL flag size=11 as illegal.
REQ-025 SHALL, on any flagged request, perform no write, set rd=0 and err=1 with normal latency.
REQ-026 SHALL, on loads, select byte lane a[1:0] or half lane a[1], then sign- or zero-extend per uns.
REQ-027 SHALL, on stores, write only the addressed byte(s) via byte enables; other bytes of the word unchanged.
REQ-028 SHALL use little-endian lane order (a[1:0]=00 -> bits [7:0]).

Reset
REQ-029 SHALL, while rst_n=0, force state IDLE, counter 0, ready=0, err=0, rd=0 immediately (asynchronously).
REQ-030 SHALL leave memory contents unaffected by reset; reset before the access edge aborts the request with no write.

Verification
REQ-031 SHALL, with WAIT=1: store word 0xDEADBEEF at 0x10, then load word 0x10 -> ready pulse on 2nd cycle after each accept edge, rd=0xDEADBEEF, err=0.
REQ-032 SHALL, with word 0x10=0xDEADBEEF, load byte 0x13 with uns=0 -> rd=0xFFFFFFDE; with uns=1 -> rd=0x000000DE; load half 0x10, uns=0 -> rd=0xFFFFBEEF.
REQ-033 SHALL, with word 0x20=0x11223344, store byte 0xAA to 0x21 -> subsequent word load of 0x20 returns 0x1122AA44.
REQ-034 SHALL flag word store to 0x22, half load from 0x05, size=11, and word load from 0x100 (DEPTH=64) -> err=1, rd=0, target memory unchanged.
REQ-035 SHALL, with WAIT=3: accept store of 0x55 to 0x30, pull rst_n low one cycle after accept -> ready never asserts, word 0x30 keeps prior value, state IDLE after release.
REQ-036 SHALL, holding req=1 continuously with WAIT=0: accepts occur every 2 cycles, req ignored during DONE, ready pulses one cycle each.
